// File: rtl/sum_rom_arbiter_pkg.sv
// Shared types and constants for the sum ROM arbiter: FSM states, ROM geometry
// and the function that builds the A+B lookup table.
package sum_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        RESP
    } arb_state_t;

    localparam int SUM_ROM_DEPTH = 16;
    localparam int SUM_ROM_AW    = 4;
    localparam int SUM_W         = 3;

    typedef logic [SUM_W-1:0] sum_rom_t [SUM_ROM_DEPTH];

    // Entry {A,B} holds A+B; A sits in the two MSBs of the index.
    function automatic sum_rom_t sum_rom_init();
        sum_rom_t tbl;
        for (int i = 0; i < SUM_ROM_DEPTH; i++) begin
            tbl[i] = SUM_W'(i[3:2]) + SUM_W'(i[1:0]);
        end
        return tbl;
    endfunction

endpackage

// File: rtl/sum_rom_arbiter_if.sv
// Requester-side bundle of the sum ROM arbiter: level req / pulse ack handshake,
// packed 2-bit operands per requester, tagged sum response and busy flag.
interface sum_rom_arbiter_if
    import sum_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req;
    logic [2*NREQ-1:0] a_in;
    logic [2*NREQ-1:0] b_in;
    logic [NREQ-1:0]   ack;
    logic              resp_valid;
    logic [IDW-1:0]    resp_id;
    logic [SUM_W-1:0]  resp_sum;
    logic              busy;

    modport master (
        output req, a_in, b_in,
        input  ack, resp_valid, resp_id, resp_sum, busy
    );

    modport slave (
        input  req, a_in, b_in,
        output ack, resp_valid, resp_id, resp_sum, busy
    );
endinterface

// File: rtl/sum_rom_arbiter_rom.sv
// sum_rom: 16x3 constant A+B table with a registered output (one-cycle read).
// Contents never change, so the output register carries no reset.
module sum_rom
    import sum_arb_pkg::*;
(
    input  logic                  clk,
    input  logic [SUM_ROM_AW-1:0] idx,
    output logic [SUM_W-1:0]      q
);
    localparam sum_rom_t ROM = sum_rom_init();

    always_ff @(posedge clk) begin
        q <= ROM[idx];
    end
endmodule

// File: rtl/sum_rom_arbiter.sv
// sum_rom_arbiter: grants one of NREQ requesters at a time to a shared sum ROM.
// Define SUM_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module sum_rom_arbiter
    import sum_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input logic              CLK100MHZ,
    input logic              RST,
    sum_rom_arbiter_if.slave bus
);
    arb_state_t       state_q;
    logic [NREQ-1:0]  rot;
    logic             win_found;
    logic [IDW-1:0]   win_id;
    logic [1:0]       a_sel;
    logic [1:0]       b_sel;

    logic [1:0]       a_p0;
    logic [1:0]       b_p0;
    logic [IDW-1:0]   id_p0;
    logic [SUM_W-1:0] sum_p1;

    logic [NREQ-1:0]  ack_q;
    logic             vld_q;
    logic [IDW-1:0]   id_q;
    logic [SUM_W-1:0] sum_q;
    logic             busy_q;
`ifdef SUM_ARB_RR_EN
    logic [IDW-1:0]   ptr_q;
`endif

    // Rotate requests so bit 0 is the current highest-priority requester.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
`ifdef SUM_ARB_RR_EN
        rot = NREQ'({bus.req, bus.req} >> ptr_q);
`else
        rot = bus.req;
`endif
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && rot[k]) begin
                win_found = 1'b1;
`ifdef SUM_ARB_RR_EN
                win_id = IDW'((int'(ptr_q) + k) % NREQ);
`else
                win_id = IDW'(k);
`endif
            end
        end
    end

    assign a_sel = 2'(bus.a_in >> {win_id, 1'b0});
    assign b_sel = 2'(bus.b_in >> {win_id, 1'b0});

    // Stage p0: winner id and operands captured at grant.
    always_ff @(posedge CLK100MHZ) begin
        if (state_q == IDLE && win_found) begin
            a_p0  <= a_sel;
            b_p0  <= b_sel;
            id_p0 <= win_id;
        end
    end

    // Stage p1: ROM output register loads during LOOKUP.
    sum_rom u_rom (
        .clk (CLK100MHZ),
        .idx ({a_p0, b_p0}),
        .q   (sum_p1)
    );

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ack_q   <= '0;
            vld_q   <= 1'b0;
            id_q    <= '0;
            sum_q   <= '0;
`ifdef SUM_ARB_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            ack_q <= '0;
            vld_q <= 1'b0;
            id_q  <= '0;
            sum_q <= '0;
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        state_q <= LOOKUP;
                        busy_q  <= 1'b1;
                    end
                end
                LOOKUP: state_q <= RESP;
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ack_q   <= NREQ'(1) << id_p0;
                    vld_q   <= 1'b1;
                    id_q    <= id_p0;
                    sum_q   <= sum_p1;
`ifdef SUM_ARB_RR_EN
                    ptr_q   <= (id_p0 == IDW'(NREQ - 1)) ? '0 : id_p0 + 1'b1;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ack        = ack_q;
    assign bus.resp_valid = vld_q;
    assign bus.resp_id    = id_q;
    assign bus.resp_sum   = sum_q;
    assign bus.busy       = busy_q;
endmodule

// File: doc/sum_rom_arbiter.md
# sum_rom_arbiter

Shares a single 16-entry sum lookup ROM between `NREQ` requesters, e.g. switch banks, display digit updaters and a self-test sequencer. Each requester presents two 2-bit operands on a level req / pulse ack handshake. The arbiter grants one requester at a time, performs a registered ROM lookup and returns a 3-bit sum tagged with the requester id. It sits between the operand sources and the seven-segment display path on the 100 MHz fabric clock.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `IDW`, default 2: width of requester id; must be ≥ ceil(log2(NREQ)).
- `CLK100MHZ`  in  1: single system clock, rising edge.
- `RST`  in  1: asynchronous, active-high reset.
- `req`  in  NREQ: per-requester request level.
- `a_in`  in  2*NREQ: operand A; requester i uses bits [2i+1:2i].
- `b_in`  in  2*NREQ: operand B; same packing as `a_in`.
- `ack`  out  NREQ: one-cycle completion pulse to the served requester.
- `resp_valid`  out  1: one-cycle pulse; `resp_sum` and `resp_id` are valid.
- `resp_id`  out  IDW: index of the served requester.
- `resp_sum`  out  3: A+B, range 0..6.
- `busy`  out  1: high in LOOKUP and RESP.

## Operation
- FSM states: IDLE, LOOKUP, RESP.
- **IDLE**
  - If any `req` bit is high, select a winner using the arbitration rule below.
  - Latch the winner's id and operands.
  - Present ROM index {A,B} (A in the MSBs) and go to LOOKUP.
  - With no requests, stay in IDLE.
- **LOOKUP**: the ROM output register loads the sum. Go to RESP.
- **RESP**
  - Drive `resp_valid`=1, `ack[id]`=1, `resp_id`=latched id and `resp_sum`=ROM output.
  - Advance the priority pointer and return to IDLE.
- **ROM contents**: entry {A,B} = A+B, zero-extended to 3 bits, for all 16 entries. Fixed at elaboration, read-only.
- **Requester rules**
  - Hold `req` and operands stable until `ack`.
  - Operands are captured at grant, so later changes are ignored.
  - `req` still high in the IDLE cycle after `ack` counts as a new request.
- **Dropped request**: a `req` that falls before grant is never served. No error is flagged.
- **Outputs outside RESP**: `ack`=0, `resp_valid`=0, `resp_id`=0, `resp_sum`=0.
- **Reset values**: all outputs 0, FSM in IDLE, priority pointer 0.
- **Reset mid-transaction**: the transaction is dropped with no `ack`. A requester still holding `req` after release is re-arbitrated from pointer 0.

## Timing
- A request sampled in IDLE at edge N produces `ack`/`resp_valid` high between edges N+2 and N+3.
- Throughput: one response per 3 cycles under continuous load.
- Maximum wait for requester i under round-robin with all requesters active: NREQ-1 transactions.
- All outputs are registered; there is no combinational path from `req` to `ack`.

## Configuration
- Macro: `SUM_ARB_RR_EN`.
- **Defined (round-robin)**
  - The pointer holds the highest-priority index.
  - After serving i, the pointer becomes (i+1) mod NREQ, wrapping from NREQ-1 to 0.
  - Search order is pointer, pointer+1, … with wrap-around.
- **Undefined (fixed priority)**
  - The lowest index always wins.
  - The pointer register is not built.
  - Higher indices can starve.

## Structure
- Package `sum_arb_pkg` holds:
  - the state enum `arb_state_t` (IDLE, LOOKUP, RESP);
  - the constants `SUM_ROM_DEPTH`=16, `SUM_ROM_AW`=4 and `SUM_W`=3;
  - the ROM initialisation function `sum_rom_init`.
- Sub-module `sum_rom`: 16x3 ROM with a registered output and one-cycle read latency. It has clock and index ports only and no reset (its contents are constant).
- The arbitration logic stays inside `sum_rom_arbiter`.

## Test plan
- **Single request:** Reset, then `req`[0]=1 with A=3, B=3 → `ack[0]` and `resp_valid` 2 cycles after the sample; `resp_sum`=6, `resp_id`=0.
- **Exhaustive operands:** All 16 (A,B) pairs via requester 2 → each `resp_sum`=A+B (0..6), `resp_id`=2.
- **Two requesters held high (RR):** `req`[0] and `req`[1] high continuously with `SUM_ARB_RR_EN` defined → ids 0,1,0,1. Without the macro → ids 0,0,0,0.
- **Pointer wrap:** Serve requester 3, then assert `req`[0] and `req`[3] together → id 0 wins under RR, then id 3.
- **Reset during LOOKUP:** Assert `RST` while in LOOKUP → all outputs 0 immediately and no `ack`. After release with `req`[1] still high → served with `resp_id`=1 three cycles later.
- **Request dropped before grant:** Raise `req`[2] while the arbiter is busy serving requester 0, then drop it before the arbiter returns to IDLE → no `ack[2]`; `busy` falls after requester 0's RESP.
